// File: rtl/tbuf_miss_ctrl.sv
// Fetch-buffer miss controller: queues CAM misses, allocates a CAM slot, then issues one downstream request at a time.
// Optional build macro TBUF_MISS_DEDUP_EN folds same-cycle misses to one address into a single entry.
module tbuf_miss_ctrl #(
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              except,
   input  logic              except_thread,
   input  logic [ADDR_W-1:0] fet_addr0,
   input  logic [ADDR_W-1:0] fet_addr1,
   input  logic              fet_en0,
   input  logic              fet_en1,
   input  logic              fet_thread,
   output logic              fet_stall,
   output logic [ADDR_W-1:0] chk_addr0,
   output logic [ADDR_W-1:0] chk_addr1,
   input  logic              chk_match0,
   input  logic              chk_match1,
   input  logic              free,
   output logic [ADDR_W-1:0] new_addr,
   output logic              new_thread,
   output logic              new_en,
   output logic [ADDR_W-1:0] req_addr,
   output logic              req_thread,
   output logic              req_valid,
   input  logic              req_ready
);
   localparam int unsigned CNT_W = 2;

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
   typedef struct packed {
      logic              thread;
      logic [ADDR_W-1:0] addr;
   } ent_t;

   state_t           state_q, state_d;
   ent_t             ent0_q, ent0_d;
   ent_t             ent1_q, ent1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ent_t             req_q, req_d;
   logic             alloc;
   logic             flush_fet;
   logic             miss0, miss1, enq1;
   logic             keep0, keep1;

   // CAM lookup addresses pass straight through
   assign chk_addr0  = fet_addr0;
   assign chk_addr1  = fet_addr1;

   // Outputs are forced quiet while reset is held so a live handshake drops immediately
   assign fet_stall  = (cnt_q != '0) && !rst;
   assign new_addr   = (cnt_q != '0) ? ent0_q.addr : '0;
   assign new_thread = (cnt_q != '0) ? ent0_q.thread : 1'b0;
   assign new_en     = alloc && !rst;
   assign req_valid  = (state_q == REQ) && !rst;
   assign req_addr   = rst ? '0 : req_q.addr;
   assign req_thread = rst ? 1'b0 : req_q.thread;

   // Request FSM: allocate from the FIFO head, then hold the request until accepted
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      alloc   = 1'b0;
      case (state_q)
         IDLE: begin
            if ((cnt_q != '0) && free) begin
               alloc   = 1'b1;
               req_d   = ent0_q;
               state_d = REQ;
            end
         end
         REQ: begin
            if (req_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Miss FIFO: fills only when empty (fetch stalls otherwise); pop and flush share one keep mask
   always_comb begin
      flush_fet = except && (except_thread == fet_thread);
      miss0     = fet_en0 && !chk_match0 && !fet_stall && !flush_fet;
      miss1     = fet_en1 && !chk_match1 && !fet_stall && !flush_fet;
`ifdef TBUF_MISS_DEDUP_EN
      enq1      = miss1 && !(miss0 && (fet_addr0 == fet_addr1));
`else
      enq1      = miss1;
`endif
      keep0     = (cnt_q != '0) && !alloc && !(except && (ent0_q.thread == except_thread));
      keep1     = (cnt_q == CNT_W'(2)) && !(except && (ent1_q.thread == except_thread));
      ent0_d    = ent0_q;
      ent1_d    = ent1_q;
      cnt_d     = cnt_q;
      if (cnt_q == '0) begin
         cnt_d = CNT_W'(miss0) + CNT_W'(enq1);
         if (miss0) begin
            ent0_d = '{thread: fet_thread, addr: fet_addr0};
            ent1_d = '{thread: fet_thread, addr: fet_addr1};
         end else if (enq1) begin
            ent0_d = '{thread: fet_thread, addr: fet_addr1};
         end
      end else begin
         cnt_d = CNT_W'(keep0) + CNT_W'(keep1);
         if (!keep0 && keep1) ent0_d = ent1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ent0_q  <= '0;
         ent1_q  <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         req_q   <= req_d;
      end
   end

endmodule

// File: tb/tb_tbuf_miss_ctrl.sv
// Scoreboard bench for tbuf_miss_ctrl: a queue-based reference model predicts every cycle's outputs;
// a negedge monitor pops and compares them and logs accepted requests for the directed scenarios.
module tb_tbuf_miss_ctrl;
   localparam int unsigned AW = 11;
`ifdef TBUF_MISS_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   typedef struct packed {
      logic          thr;
      logic [AW-1:0] addr;
   } ent_t;

   typedef struct packed {
      logic          rst;
      logic          except;
      logic          except_thread;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic          en0;
      logic          en1;
      logic          fet_thread;
      logic          m0;
      logic          m1;
      logic          free;
      logic          ready;
   } stim_t;

   typedef struct packed {
      logic          rst;
      logic          stall;
      logic          new_en;
      logic          new_thr;
      logic [AW-1:0] new_addr;
      logic          req_valid;
      logic          req_thr;
      logic [AW-1:0] req_addr;
      logic [AW-1:0] chk0;
      logic [AW-1:0] chk1;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst, except, except_thread;
   logic [AW-1:0] fet_addr0, fet_addr1;
   logic          fet_en0, fet_en1, fet_thread;
   logic          fet_stall;
   logic [AW-1:0] chk_addr0, chk_addr1;
   logic          chk_match0, chk_match1, free;
   logic [AW-1:0] new_addr;
   logic          new_thread, new_en;
   logic [AW-1:0] req_addr;
   logic          req_thread, req_valid, req_ready;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];
   ent_t obs_q[$];

   // Reference model state: pending misses in order, plus the request being held downstream
   ent_t mq[$];
   bit   busy = 1'b0;
   ent_t held = '0;

   tbuf_miss_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .except(except), .except_thread(except_thread),
      .fet_addr0(fet_addr0), .fet_addr1(fet_addr1), .fet_en0(fet_en0), .fet_en1(fet_en1),
      .fet_thread(fet_thread), .fet_stall(fet_stall), .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
      .chk_match0(chk_match0), .chk_match1(chk_match1), .free(free),
      .new_addr(new_addr), .new_thread(new_thread), .new_en(new_en),
      .req_addr(req_addr), .req_thread(req_thread), .req_valid(req_valid), .req_ready(req_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic stim_t idle_s();
      stim_t s;
      s       = '0;
      s.free  = 1'b1;
      s.ready = 1'b1;
      return s;
   endfunction

   // Apply one cycle of stimulus, predict this cycle's outputs, then advance the model past the edge
   task automatic cyc(input stim_t s);
      exp_t e;
      ent_t keep[$];
      bit   flush, mi0, mi1;
      @(posedge clk);
      #1;
      rst = s.rst; except = s.except; except_thread = s.except_thread;
      fet_addr0 = s.a0; fet_addr1 = s.a1; fet_en0 = s.en0; fet_en1 = s.en1;
      fet_thread = s.fet_thread; chk_match0 = s.m0; chk_match1 = s.m1;
      free = s.free; req_ready = s.ready;
      e      = '0;
      e.rst  = s.rst;
      e.chk0 = s.a0;
      e.chk1 = s.a1;
      if (s.rst) begin
         mq.delete();
         busy = 1'b0;
         held = '0;
      end else begin
         e.stall = (mq.size() != 0);
         if (mq.size() != 0) begin
            e.new_addr = mq[0].addr;
            e.new_thr  = mq[0].thr;
         end
         e.new_en    = !busy && (mq.size() != 0) && s.free;
         e.req_valid = busy;
         e.req_addr  = held.addr;
         e.req_thr   = held.thr;
         flush = s.except && (s.except_thread == s.fet_thread);
         mi0   = s.en0 && !s.m0 && !e.stall && !flush;
         mi1   = s.en1 && !s.m1 && !e.stall && !flush;
         if (e.new_en) begin
            held = mq.pop_front();
            busy = 1'b1;
         end else if (busy && s.ready) begin
            busy = 1'b0;
         end
         if (s.except) begin
            foreach (mq[i]) if (mq[i].thr != s.except_thread) keep.push_back(mq[i]);
            mq = keep;
         end
         if (mi0) mq.push_back('{thr: s.fet_thread, addr: s.a0});
         if (mi1 && !(DEDUP && mi0 && (s.a0 == s.a1))) mq.push_back('{thr: s.fet_thread, addr: s.a1});
      end
      exp_q.push_back(e);
   endtask

   task automatic settle(input int n);
      repeat (n) cyc(idle_s());
      @(negedge clk);
      #1;
   endtask

   task automatic exp_count(input string name, input int n);
      chk({name, " req count"}, 32'(obs_q.size()), 32'(n));
   endtask

   task automatic exp_req(input string name, input int i, input logic thr, input logic [AW-1:0] addr);
      if (i < obs_q.size()) begin
         chk({name, " req_addr"}, 32'(obs_q[i].addr), 32'(addr));
         chk({name, " req_thread"}, 32'(obs_q[i].thr), 32'(thr));
      end
   endtask

   // Monitor: compare every cycle against the model and record accepted requests
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("chk_addr0", 32'(chk_addr0), 32'(e.chk0));
            chk("chk_addr1", 32'(chk_addr1), 32'(e.chk1));
            chk("fet_stall", 32'(fet_stall), 32'(e.stall));
            chk("new_en", 32'(new_en), 32'(e.new_en));
            chk("req_valid", 32'(req_valid), 32'(e.req_valid));
            if (!e.rst) begin
               chk("new_addr", 32'(new_addr), 32'(e.new_addr));
               chk("new_thread", 32'(new_thread), 32'(e.new_thr));
            end
            if (e.rst || e.req_valid) begin
               chk("req_addr", 32'(req_addr), 32'(e.req_addr));
               chk("req_thread", 32'(req_thread), 32'(e.req_thr));
            end
         end
         if (req_valid && req_ready) obs_q.push_back('{thr: req_thread, addr: req_addr});
      end
   end

   initial begin
      stim_t s;
      s = idle_s();
      s.rst = 1'b1;
      rst = 1'b1; except = 1'b0; except_thread = 1'b0; fet_addr0 = '0; fet_addr1 = '0;
      fet_en0 = 1'b0; fet_en1 = 1'b0; fet_thread = 1'b0; chk_match0 = 1'b0; chk_match1 = 1'b0;
      free = 1'b1; req_ready = 1'b1;
      cyc(s);
      cyc(s);
      settle(2);
      obs_q.delete();

      // Single miss: alloc next cycle, one-cycle request the cycle after
      s = idle_s(); s.en0 = 1'b1; s.a0 = 11'h123;
      cyc(s);
      settle(6);
      exp_count("single", 1);
      exp_req("single", 0, 1'b0, 11'h123);
      obs_q.delete();

      // Two misses, thread 1, issued in lookup order
      s = idle_s(); s.en0 = 1'b1; s.en1 = 1'b1; s.a0 = 11'h010; s.a1 = 11'h020; s.fet_thread = 1'b1;
      cyc(s);
      settle(8);
      exp_count("pair", 2);
      exp_req("pair0", 0, 1'b1, 11'h010);
      exp_req("pair1", 1, 1'b1, 11'h020);
      obs_q.delete();

      // No free slot for 5 cycles
      s = idle_s(); s.free = 1'b0; s.en0 = 1'b1; s.a0 = 11'h0AA;
      cyc(s);
      s = idle_s(); s.free = 1'b0;
      repeat (5) cyc(s);
      settle(6);
      exp_count("nofree", 1);
      exp_req("nofree", 0, 1'b0, 11'h0AA);
      obs_q.delete();

      // Backpressure for 4 REQ cycles with an exception on the request's thread
      s = idle_s(); s.ready = 1'b0; s.en0 = 1'b1; s.a0 = 11'h0BB; s.fet_thread = 1'b1;
      cyc(s);
      s.en0 = 1'b0;
      cyc(s);
      cyc(s);
      s.except = 1'b1; s.except_thread = 1'b1;
      cyc(s);
      s.except = 1'b0;
      cyc(s);
      cyc(s);
      settle(4);
      exp_count("stall", 1);
      exp_req("stall", 0, 1'b1, 11'h0BB);
      obs_q.delete();

      // Lookups share one thread, so a mixed-thread FIFO cannot form: flush the survivor after a pop
      s = idle_s(); s.free = 1'b0; s.en0 = 1'b1; s.en1 = 1'b1; s.a0 = 11'h001; s.a1 = 11'h002;
      cyc(s);
      s = idle_s(); s.ready = 1'b0; s.except = 1'b1; s.except_thread = 1'b1;
      cyc(s);
      s.except_thread = 1'b0;
      cyc(s);
      s.except = 1'b0;
      cyc(s);
      settle(6);
      exp_count("flush", 1);
      exp_req("flush", 0, 1'b0, 11'h001);
      obs_q.delete();

      // Pop and flush hit the same head entry
      s = idle_s(); s.free = 1'b0; s.en0 = 1'b1; s.en1 = 1'b1; s.a0 = 11'h005; s.a1 = 11'h006;
      s.fet_thread = 1'b1;
      cyc(s);
      s = idle_s(); s.except = 1'b1; s.except_thread = 1'b1;
      cyc(s);
      settle(6);
      exp_count("popflush", 1);
      exp_req("popflush", 0, 1'b1, 11'h005);
      obs_q.delete();

      // Same address on both lookups
      s = idle_s(); s.en0 = 1'b1; s.en1 = 1'b1; s.a0 = 11'h055; s.a1 = 11'h055;
      cyc(s);
      settle(8);
      exp_count("dup", DEDUP ? 1 : 2);
      exp_req("dup0", 0, 1'b0, 11'h055);
      if (!DEDUP) exp_req("dup1", 1, 1'b0, 11'h055);
      obs_q.delete();

      // Random traffic against the model
      repeat (3000) begin
         s               = '0;
         s.rst           = ($urandom_range(0, 199) == 0);
         s.except        = ($urandom_range(0, 7) == 0);
         s.except_thread = 1'($urandom);
         s.a0            = AW'($urandom);
         s.a1            = ($urandom_range(0, 3) == 0) ? s.a0 : AW'($urandom);
         s.en0           = 1'($urandom);
         s.en1           = 1'($urandom);
         s.fet_thread    = 1'($urandom);
         s.m0            = ($urandom_range(0, 3) == 0);
         s.m1            = ($urandom_range(0, 3) == 0);
         s.free          = ($urandom_range(0, 3) != 0);
         s.ready         = ($urandom_range(0, 2) != 0);
         cyc(s);
      end
      settle(10);
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
